snake_body_store: RTL and testbench

- Holds the snake body segment coordinates, index 0 next to the head and index snake_length-1 as the tail.
- Sits between snake_game_fsm (move/grow decisions, head position) and graphic_game.
- Feeds graphic_game's body mirror through the serial body_count / snake_body_x / snake_body_y write stream, plus snake_length and the tail-direction flags.
- On each move it shifts the body serially, inserts the old head, and checks the new head against the new body (self-collision).

---
 rtl/snake_body_if.sv | 45 ++++
 rtl/snake_body_store.sv | 232 +++++++++++++++++++++++
 tb/tb_snake_body_store.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_body_if.sv
// Control and body-stream bus of snake_body_store.
// master: game FSM / renderer side, slave: the body store.
interface snake_body_if #(
    parameter int LB = 7
);
    logic          start;
    logic          move;
    logic          grow;
    logic [6:0]    old_head_x;
    logic [6:0]    old_head_y;
    logic [6:0]    new_head_x;
    logic [6:0]    new_head_y;
    logic [LB-1:0] body_count;
    logic [6:0]    snake_body_x;
    logic [6:0]    snake_body_y;
    logic [LB-1:0] snake_length;
    logic          up_tail;
    logic          down_tail;
    logic          left_tail;
    logic          right_tail;
    logic          busy;
    logic          done;
    logic          self_hit;
    logic          length_max;

    modport master (
        output start, move, grow,
        output old_head_x, old_head_y,
        output new_head_x, new_head_y,
        input  body_count, snake_body_x, snake_body_y,
        input  snake_length,
        input  up_tail, down_tail, left_tail, right_tail,
        input  busy, done, self_hit, length_max
    );

    modport slave (
        input  start, move, grow,
        input  old_head_x, old_head_y,
        input  new_head_x, new_head_y,
        output body_count, snake_body_x, snake_body_y,
        output snake_length,
        output up_tail, down_tail, left_tail, right_tail,
        output busy, done, self_hit, length_max
    );
endinterface

// File: rtl/snake_body_store.sv
// Snake body segment store: serial shift on move, self-collision check,
// tail direction and a continuous (index, coordinate) mirror stream.
module snake_body_store #(
    parameter int SNAKE_LENGTH_BIT = 7,
    parameter int SNAKE_LENGTH_MAX = 2**SNAKE_LENGTH_BIT,
    parameter int INIT_LENGTH      = 3,
    parameter int HEAD_X0          = 20,
    parameter int HEAD_Y0          = 40,
    parameter int GRID_W           = 124,
    parameter int GRID_H           = 81
) (
    input logic         clock_25,
    input logic         reset,
    snake_body_if.slave bus
);
    localparam int NENT = SNAKE_LENGTH_MAX;

    typedef logic [SNAKE_LENGTH_BIT-1:0] idx_t;
    typedef logic [6:0]                  crd_t;

    localparam idx_t LAST = idx_t'(SNAKE_LENGTH_MAX - 2);
    localparam idx_t LMAX = idx_t'(SNAKE_LENGTH_MAX - 1);
    localparam idx_t ILEN = idx_t'(INIT_LENGTH);
    localparam crd_t XMAX = crd_t'(GRID_W - 1);
    localparam crd_t YMAX = crd_t'(GRID_H - 1);
    localparam crd_t X0   = crd_t'(HEAD_X0);
    localparam crd_t Y0   = crd_t'(HEAD_Y0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHIFT,
        S_HEAD_WR,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    crd_t       ent_x_q [NENT];
    crd_t       ent_y_q [NENT];
    crd_t       head_x_q, head_x_d;
    crd_t       head_y_q, head_y_d;
    crd_t       nh_x_q, nh_x_d;
    crd_t       nh_y_q, nh_y_d;
    idx_t       idx_q, idx_d;
    idx_t       len_q, len_d;
    idx_t       lnew_q, lnew_d;
    idx_t       cnt_q, cnt_d;
    crd_t       sx_q, sx_d;
    crd_t       sy_q, sy_d;
    logic       hit_q, hit_d;
    logic [3:0] tail_q, tail_d;

    logic       we;
    idx_t       wa;
    crd_t       wx, wy;
    logic       lmax;

    idx_t       t_i, a_i;
    crd_t       tx, ty, ax, ay;
    crd_t       txp, txm, typ, tym;

    assign lmax = (len_q == LMAX);

    // Tail segment and its neighbour toward the head, with grid wrap.
    always_comb begin
        t_i = len_q - idx_t'(1);
        a_i = len_q - idx_t'(2);
        tx  = ent_x_q[t_i];
        ty  = ent_y_q[t_i];
        ax  = (len_q == idx_t'(1)) ? head_x_q : ent_x_q[a_i];
        ay  = (len_q == idx_t'(1)) ? head_y_q : ent_y_q[a_i];
        txp = (tx == XMAX) ? '0 : tx + 7'd1;
        txm = (tx == '0) ? XMAX : tx - 7'd1;
        typ = (ty == YMAX) ? '0 : ty + 7'd1;
        tym = (ty == '0) ? YMAX : ty - 7'd1;
    end

    always_comb begin
        state_d  = state_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        nh_x_d   = nh_x_q;
        nh_y_d   = nh_y_q;
        idx_d    = idx_q;
        len_d    = len_q;
        lnew_d   = lnew_q;
        hit_d    = hit_q;
        tail_d   = tail_q;
        we       = 1'b0;
        wa       = idx_q;
        wx       = ent_x_q[idx_q - idx_t'(1)];
        wy       = ent_y_q[idx_q - idx_t'(1)];
        cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + idx_t'(1);
        sx_d     = ent_x_q[cnt_d];
        sy_d     = ent_y_q[cnt_d];

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_INIT;
                    idx_d    = '0;
                    hit_d    = 1'b0;
                    head_x_d = X0;
                    head_y_d = Y0;
                end else if (bus.move && len_q != '0) begin
                    nh_x_d = bus.new_head_x;
                    nh_y_d = bus.new_head_y;
                    hit_d  = 1'b0;
                    lnew_d = (bus.grow && !lmax)
                           ? len_q + idx_t'(1) : len_q;
                    idx_d  = lnew_d - idx_t'(1);
                    state_d = (lnew_d == idx_t'(1))
                            ? S_HEAD_WR : S_SHIFT;
                end
            end
            S_INIT: begin
                we    = 1'b1;
                wx    = crd_t'(HEAD_X0 - 1) - crd_t'(idx_q);
                wy    = Y0;
                cnt_d = idx_q;
                sx_d  = wx;
                sy_d  = wy;
                if (idx_q == ILEN - idx_t'(1)) begin
                    len_d   = ILEN;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + idx_t'(1);
                end
            end
            S_SHIFT: begin
                we    = 1'b1;
                cnt_d = idx_q;
                sx_d  = wx;
                sy_d  = wy;
                hit_d = hit_q | (wx == nh_x_q && wy == nh_y_q);
                idx_d = idx_q - idx_t'(1);
                if (idx_q == idx_t'(1)) begin
                    state_d = S_HEAD_WR;
                end
            end
            S_HEAD_WR: begin
                we       = 1'b1;
                wa       = '0;
                wx       = bus.old_head_x;
                wy       = bus.old_head_y;
                cnt_d    = '0;
                sx_d     = wx;
                sy_d     = wy;
                hit_d    = hit_q | (wx == nh_x_q && wy == nh_y_q);
                head_x_d = nh_x_q;
                head_y_d = nh_y_q;
                len_d    = lnew_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                cnt_d = '0;
                sx_d  = ent_x_q[0];
                sy_d  = ent_y_q[0];
                if (len_q == '0)   tail_d = 4'b0000;
                else if (ax == txp) tail_d = 4'b0001;
                else if (ax == txm) tail_d = 4'b0010;
                else if (ay == typ) tail_d = 4'b0100;
                else if (ay == tym) tail_d = 4'b1000;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            head_x_q <= '0;
            head_y_q <= '0;
            nh_x_q   <= '0;
            nh_y_q   <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            lnew_q   <= '0;
            cnt_q    <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            hit_q    <= 1'b0;
            tail_q   <= '0;
        end else begin
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            nh_x_q   <= nh_x_d;
            nh_y_q   <= nh_y_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            lnew_q   <= lnew_d;
            cnt_q    <= cnt_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            hit_q    <= hit_d;
            tail_q   <= tail_d;
        end
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NENT; i++) begin
                ent_x_q[i] <= '0;
                ent_y_q[i] <= '0;
            end
        end else if (we) begin
            ent_x_q[wa] <= wx;
            ent_y_q[wa] <= wy;
        end
    end

    assign bus.body_count   = cnt_q;
    assign bus.snake_body_x = sx_q;
    assign bus.snake_body_y = sy_q;
    assign bus.snake_length = len_q;
    assign bus.up_tail      = tail_q[3];
    assign bus.down_tail    = tail_q[2];
    assign bus.left_tail    = tail_q[1];
    assign bus.right_tail   = tail_q[0];
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.self_hit     = (state_q == S_DONE) & hit_q;
    assign bus.length_max   = lmax;
endmodule

// File: tb/tb_snake_body_store.sv
// Directed bench for snake_body_store: init, shift, grow, self-hit,
// tail wrap, saturation at max length and asynchronous reset.
module tb_snake_body_store;
    logic clock_25 = 1'b0;
    logic reset    = 1'b0;
    int   total    = 0;
    int   bad      = 0;
    int   lat;
    logic hit;

    snake_body_if bus ();

    snake_body_store dut (
        .clock_25 (clock_25),
        .reset    (reset),
        .bus      (bus)
    );

    always #20 clock_25 = ~clock_25;

    task automatic tick();
        @(posedge clock_25);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sw(input string tag, input logic [6:0] c,
                          input logic [6:0] x, input logic [6:0] y);
        chk(tag, {11'd0, bus.body_count, bus.snake_body_x,
                  bus.snake_body_y}, {11'd0, c, x, y});
    endtask

    function automatic logic [3:0] tails();
        return {bus.up_tail, bus.down_tail,
                bus.left_tail, bus.right_tail};
    endfunction

    task automatic set_heads(input logic [6:0] ox, input logic [6:0] oy,
                             input logic [6:0] nx, input logic [6:0] ny);
        bus.old_head_x = ox;
        bus.old_head_y = oy;
        bus.new_head_x = nx;
        bus.new_head_y = ny;
    endtask

    task automatic do_move(input logic [6:0] ox, input logic [6:0] oy,
                           input logic [6:0] nx, input logic [6:0] ny,
                           input logic g, output int l, output logic h);
        set_heads(ox, oy, nx, ny);
        bus.grow = g;
        bus.move = 1'b1;
        tick();
        bus.move = 1'b0;
        bus.grow = 1'b0;
        l = 1;
        while (!bus.done && l < 300) begin
            tick();
            l++;
        end
        h = bus.self_hit;
        tick();
    endtask

    task automatic do_start();
        int l;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        l = 1;
        while (!bus.done && l < 20) begin
            tick();
            l++;
        end
        chk("start_lat", l, 4);
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.move  = 1'b0;
        bus.grow  = 1'b0;
        set_heads(7'd0, 7'd0, 7'd0, 7'd0);
        #100;
        chk("rst_cnt", bus.body_count, 0);
        chk("rst_len", bus.snake_length, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tail", tails(), 0);
        @(negedge clock_25);
        reset = 1'b1;
        tick();
        chk("idle_cnt1", bus.body_count, 1);

        // 1: initial load
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("init_busy", bus.busy, 1);
        tick();
        chk_sw("init_w0", 7'd0, 7'd19, 7'd40);
        tick();
        chk_sw("init_w1", 7'd1, 7'd18, 7'd40);
        chk("init_nd", bus.done, 0);
        tick();
        chk_sw("init_w2", 7'd2, 7'd17, 7'd40);
        chk("init_done", bus.done, 1);
        chk("init_len", bus.snake_length, 3);
        tick();
        chk("init_done_off", bus.done, 0);
        chk("init_busy_off", bus.busy, 0);
        chk_sw("idle_w0", 7'd0, 7'd19, 7'd40);
        chk("init_tail", tails(), 4'b0001);
        repeat (126) tick();
        chk_sw("idle_w126", 7'd126, 7'd0, 7'd0);
        tick();
        chk_sw("idle_wrap", 7'd0, 7'd19, 7'd40);

        // 2: plain move
        set_heads(7'd20, 7'd40, 7'd21, 7'd40);
        bus.move = 1'b1;
        tick();
        bus.move = 1'b0;
        chk("mv_busy", bus.busy, 1);
        tick();
        chk_sw("mv_w2", 7'd2, 7'd18, 7'd40);
        tick();
        chk_sw("mv_w1", 7'd1, 7'd19, 7'd40);
        chk("mv_nd", bus.done, 0);
        tick();
        chk_sw("mv_w0", 7'd0, 7'd20, 7'd40);
        chk("mv_done", bus.done, 1);
        chk("mv_hit", bus.self_hit, 0);
        chk("mv_len", bus.snake_length, 3);
        tick();
        chk("mv_tail", tails(), 4'b0001);

        // start and move together: start wins
        set_heads(7'd21, 7'd40, 7'd22, 7'd40);
        bus.start = 1'b1;
        bus.move  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.move  = 1'b0;
        tick();
        chk_sw("sm_w0", 7'd0, 7'd19, 7'd40);
        tick();
        tick();
        chk("sm_done", bus.done, 1);
        chk("sm_len", bus.snake_length, 3);
        tick();

        // 3: grow
        set_heads(7'd20, 7'd40, 7'd21, 7'd40);
        bus.grow = 1'b1;
        bus.move = 1'b1;
        tick();
        bus.move = 1'b0;
        bus.grow = 1'b0;
        tick();
        chk_sw("gr_w3", 7'd3, 7'd17, 7'd40);
        tick();
        chk_sw("gr_w2", 7'd2, 7'd18, 7'd40);
        tick();
        chk_sw("gr_w1", 7'd1, 7'd19, 7'd40);
        chk("gr_nd", bus.done, 0);
        tick();
        chk_sw("gr_w0", 7'd0, 7'd20, 7'd40);
        chk("gr_done", bus.done, 1);
        chk("gr_len", bus.snake_length, 4);
        tick();

        // 4: U shape and self collision
        do_move(7'd21, 7'd40, 7'd21, 7'd39, 1'b1, lat, hit);
        chk("u1_lat", lat, 6);
        chk("u1_hit", hit, 0);
        do_move(7'd21, 7'd39, 7'd20, 7'd39, 1'b1, lat, hit);
        chk("u2_lat", lat, 7);
        do_move(7'd20, 7'd39, 7'd20, 7'd40, 1'b0, lat, hit);
        chk("u3_lat", lat, 7);
        chk("u3_hit", hit, 1);
        chk("u3_hit_off", bus.self_hit, 0);
        chk("u3_done_off", bus.done, 0);
        chk("u3_len", bus.snake_length, 6);
        do_move(7'd20, 7'd40, 7'd18, 7'd40, 1'b0, lat, hit);
        chk("tailcell_hit", hit, 0);

        // 5: tail direction across the grid edges
        do_start();
        do_move(7'd123, 7'd5, 7'd90, 7'd60, 1'b0, lat, hit);
        do_move(7'd0, 7'd5, 7'd90, 7'd60, 1'b0, lat, hit);
        do_move(7'd1, 7'd5, 7'd90, 7'd60, 1'b0, lat, hit);
        chk("tail_xwrap", tails(), 4'b0001);
        do_move(7'd60, 7'd0, 7'd90, 7'd60, 1'b0, lat, hit);
        do_move(7'd60, 7'd80, 7'd90, 7'd60, 1'b0, lat, hit);
        chk("tail_hold", tails(), 4'b0001);
        do_move(7'd60, 7'd79, 7'd90, 7'd60, 1'b0, lat, hit);
        chk("tail_ywrap", tails(), 4'b1000);

        // 6: grow to capacity, saturate, drop busy pulses, reset
        for (int n = 0; n < 130 && !bus.length_max; n++) begin
            do_move(7'd5, 7'd5, 7'd6, 7'd6, 1'b1, lat, hit);
        end
        chk("max_len", bus.snake_length, 127);
        chk("max_flag", bus.length_max, 1);
        set_heads(7'd5, 7'd5, 7'd6, 7'd6);
        bus.grow = 1'b1;
        bus.move = 1'b1;
        tick();
        tick();
        bus.move = 1'b0;
        bus.grow = 1'b0;
        lat = 2;
        while (!bus.done && lat < 300) begin
            tick();
            lat++;
        end
        chk("sat_lat", lat, 128);
        chk("sat_len", bus.snake_length, 127);
        tick();
        chk("drop_busy1", bus.busy, 0);
        tick();
        chk("drop_busy2", bus.busy, 0);

        bus.move = 1'b1;
        tick();
        bus.move = 1'b0;
        repeat (5) tick();
        chk("mid_busy", bus.busy, 1);
        reset = 1'b0;
        #2;
        chk_sw("ar_stream", 7'd0, 7'd0, 7'd0);
        chk("ar_len", bus.snake_length, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_max", bus.length_max, 0);
        chk("ar_tail", tails(), 0);
        @(negedge clock_25);
        reset = 1'b1;
        tick();
        chk_sw("ar_clear", 7'd1, 7'd0, 7'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
